// File: rtl/type_decode_if.sv
// type_decode_if: opcode in, one-hot instruction-format flags out
interface type_decode_if;
  logic [6:0] opcode;
  logic R, I, L, Jr, S, Sb, aui, lui, J, illegal;
  modport master (output opcode, input R, I, L, Jr, S, Sb, aui, lui, J, illegal);
  modport slave (input opcode, output R, I, L, Jr, S, Sb, aui, lui, J, illegal);
endinterface

// File: rtl/type_decode.sv
// type_decode: registered RV32I major-opcode decoder with one-hot format flags
module type_decode (
  input logic clk,
  input logic rst,
  type_decode_if.slave bus
);
  logic [9:0] nxt, f;
  always_comb begin
    nxt = '0;
    nxt[9] = bus.opcode == 7'b0110011;
    nxt[8] = bus.opcode == 7'b0010011;
    nxt[7] = bus.opcode == 7'b0000011;
    nxt[6] = bus.opcode == 7'b1100111;
    nxt[5] = bus.opcode == 7'b0100011;
    nxt[4] = bus.opcode == 7'b1100011;
    nxt[3] = bus.opcode == 7'b0010111;
    nxt[2] = bus.opcode == 7'b0110111;
    nxt[1] = bus.opcode == 7'b1101111;
    nxt[0] = ~|nxt[9:1];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) f <= '0;
    else f <= nxt;
  assign {bus.R, bus.I, bus.L, bus.Jr, bus.S, bus.Sb, bus.aui, bus.lui, bus.J, bus.illegal} = f;
endmodule

// File: tb/tb_type_decode.sv
// tb_type_decode: directed and random checks of type_decode against a table model
module tb_type_decode;
  logic clk, rst;
  int checks = 0, errors = 0;
  type_decode_if bus ();
  type_decode dut (.clk(clk), .rst(rst), .bus(bus));
  localparam logic [6:0] TBL [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
    7'b0100011, 7'b1100011, 7'b0010111, 7'b0110111, 7'b1101111};
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [9:0] ref_decode(logic [6:0] op);
    for (int i = 0; i < 9; i++)
      if (op == TBL[i]) return 10'b1 << (9 - i);
    return 10'b1;
  endfunction
  function automatic logic [9:0] obs();
    return {bus.R, bus.I, bus.L, bus.Jr, bus.S, bus.Sb, bus.aui, bus.lui, bus.J, bus.illegal};
  endfunction
  task automatic check(string tag, logic [9:0] exp);
    logic [9:0] o;
    o = obs();
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, o, exp);
    end
  endtask
  task automatic step(string tag, logic [6:0] op);
    bus.opcode = op;
    @(posedge clk);
    #1 check(tag, ref_decode(op));
  endtask
  initial begin
    logic [6:0] sweep [9];
    logic [6:0] bad [5];
    logic [6:0] r;
    sweep = TBL;
    bad = '{7'b0001111, 7'b1110011, 7'b0110010, 7'b0000000, 7'b1111111};
    rst = 1;
    bus.opcode = 7'b0110011;
    #1 check("reset_async", 10'b0);
    repeat (3) @(posedge clk);
    #1 check("reset_clocked", 10'b0);
    @(negedge clk) rst = 0;
    #1 check("reset_release_hold", 10'b0);
    @(posedge clk);
    #1 check("first_edge_R", 10'b10_0000_0000);
    for (int i = 0; i < 9; i++) step($sformatf("sweep_%0d", i), sweep[i]);
    for (int i = 0; i < 5; i++) begin
      bus.opcode = bad[i];
      @(posedge clk);
      #1 check($sformatf("illegal_%0d", i), 10'b1);
    end
    step("glitch_L", 7'b0000011);
    #2 bus.opcode = 7'b0100011;
    #1 check("glitch_hold_L", 10'b00_1000_0000);
    @(posedge clk);
    #1 check("glitch_S", 10'b00_0010_0000);
    step("mid_J", 7'b1101111);
    #2 rst = 1;
    #1 check("mid_async_clear", 10'b0);
    #1 rst = 0;
    bus.opcode = 7'b0110111;
    #1 check("mid_release_hold", 10'b0);
    @(posedge clk);
    #1 check("mid_lui", 10'b00_0000_0100);
    for (int n = 0; n < 1000; n++) begin
      r = 7'($urandom);
      if (n % 4 == 0) r = TBL[$urandom_range(0, 8)];
      step("random", r);
      checks++;
      assert ($countones(obs()) == 1) else begin
        errors++;
        $error("FAIL onehot observed %b expected one bit set", obs());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/type_decode.md
Name: type_decode

Overview:
- Registered RV32I instruction-format decoder.
- Takes the 7-bit major opcode (instr[6:0]) from the fetch/decode stage and produces one-hot format/class flags for the control unit.
- Flags cover R, I-ALU, load, JALR, store, branch, AUIPC, LUI, JAL and an illegal-opcode flag.
- Outputs are registered: one clock of latency, asynchronous active-high clear.

Parameters:
- None. Opcode width is fixed at 7 bits.

Ports:
- clk  input  1  system clock; all outputs update on its rising edge
- rst  input  1  asynchronous, active-high reset; clears every output
- opcode  input  7  instruction bits [6:0]
- R  output  1  register-register ALU (OP, 0110011)
- I  output  1  immediate ALU (OP-IMM, 0010011)
- L  output  1  load (LOAD, 0000011)
- Jr  output  1  jump-and-link-register (JALR, 1100111)
- S  output  1  store (STORE, 0100011)
- Sb  output  1  conditional branch (BRANCH, 1100011)
- aui  output  1  add upper immediate to PC (AUIPC, 0010111)
- lui  output  1  load upper immediate (LUI, 0110111)
- J  output  1  jump-and-link (JAL, 1101111)
- illegal  output  1  opcode not in the supported set above

Behaviour:
- Reset:
  - While rst=1, all ten outputs are 0, regardless of clk.
  - Clearing is asynchronous: it takes effect immediately on rst rising, with no clock edge required.
  - After rst deasserts, outputs remain 0 until the first rising clk edge.
- Decode:
  - On each rising clk edge with rst=0, all ten outputs are registered from the current opcode.
  - Latency is exactly 1 cycle: outputs at cycle n+1 reflect the opcode sampled at edge n.
- Mapping: exact full 7-bit compare against the nine encodings listed in Ports; each match sets only its own flag.
- Illegal:
  - Any other opcode sets illegal=1 and all nine type flags to 0.
  - This explicitly includes MISC-MEM/FENCE (0001111), SYSTEM (1110011), and any value with opcode[1:0] != 2'b11 (compressed/invalid).
- One-hot invariant: after the first post-reset edge, exactly one of {R, I, L, Jr, S, Sb, aui, lui, J, illegal} is 1 every cycle. During reset all are 0.
- No enable or handshake. The decoder samples every cycle and holds the last value between edges.
- Opcode changes between edges have no effect on outputs until the next rising edge (no combinational path from opcode to outputs).
- Reset mid-operation: asserting rst at any time forces all outputs to 0 immediately. Decoding resumes on the first edge after deassertion.
- Unknown/X opcode bits: behaviour is undefined for synthesis. The verification bench shall not drive X after reset release.

Test Plan:
- Reset: rst=1 with opcode=0110011, clocks running -> all ten outputs 0. Release rst; after next edge R=1, all others 0.
- Full sweep, one per cycle: 0110011, 0010011, 0000011, 1100111, 0100011, 1100011, 0010111, 0110111, 1101111 -> respectively R, I, L, Jr, S, Sb, aui, lui, J high alone, each one cycle after its opcode is applied; illegal=0 throughout.
- Unsupported opcodes: 0001111 (FENCE), 1110011 (SYSTEM), 0110010 (bits[1:0]=10), 0000000, 1111111 -> illegal=1, all type flags 0, one cycle later.
- Latency/glitch: change opcode from 0000011 to 0100011 mid-cycle -> L stays 1 until the next rising edge, then S=1 and L=0 on that edge, with no intermediate output change.
- Async reset mid-stream: while J=1, pulse rst high between clock edges -> all outputs drop to 0 immediately, without waiting for a clock edge. After release and one edge with opcode=0110111 -> lui=1.
- Random: 1000 random 7-bit opcodes -> the one-hot invariant holds every cycle and the output matches a reference table lookup of the previous-cycle opcode.
